cldiv: RTL and testbench



---
 rtl/cldiv_pkg.sv | 8 +
 rtl/cldiv_if.sv | 14 +
 rtl/cldiv_lead_one.sv | 16 +
 rtl/cldiv.sv | 93 +++++++++
 tb/tb_cldiv.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/cldiv_pkg.sv
// Shared constants and types for the carry-less divider.
package cldiv_pkg;
  localparam int DIVIDEND_W = 64;
  localparam int DIVISOR_W  = 32;
  localparam int DEG_W      = 5;

  typedef logic [DEG_W-1:0] deg_t;
endpackage

// File: rtl/cldiv_if.sv
// start/stall/eoc handshake and operand/result bus of the carry-less divider.
interface cldiv_if;
  logic                                start;
  logic                                stall;
  logic                                eoc;
  logic [cldiv_pkg::DIVIDEND_W-1:0]    A;
  logic [cldiv_pkg::DIVISOR_W-1:0]     B;
  logic [cldiv_pkg::DIVIDEND_W-1:0]    quo;
  logic [cldiv_pkg::DIVISOR_W-1:0]     rem;
  logic                                div_zero;

  modport master (output start, stall, A, B, input eoc, quo, rem, div_zero);
  modport slave  (input start, stall, A, B, output eoc, quo, rem, div_zero);
endinterface

// File: rtl/cldiv_lead_one.sv
// 32-bit leading-one detector: index of the highest set bit plus a zero flag.
module cl_lead_one
  import cldiv_pkg::*;
(
  input  logic [DIVISOR_W-1:0] v,
  output deg_t                 deg,
  output logic                 zero
);
  // Scan low to high so the highest set bit wins.
  always_comb begin
    deg  = '0;
    zero = (v == '0);
    for (int i = 0; i < DIVISOR_W; i++)
      if (v[i]) deg = deg_t'(i);
  end
endmodule

// File: rtl/cldiv.sv
// Multi-cycle carry-less (GF(2)) divider: 64-bit dividend by 32-bit divisor.
// Resolves STEPS_PER_CYCLE quotient bits per cycle, high chunk first.
// Optional macro CLDIV_EARLY_EXIT_EN: skip leading chunks that cannot hold
// quotient bits (variable latency, identical result).
module cldiv
  import cldiv_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 8
) (
  input  logic   clk,
  input  logic   resetn,
  cldiv_if.slave bus
);
  localparam int CYC_COUNT  = DIVIDEND_W / STEPS_PER_CYCLE;
  localparam int STATE_BITS = $clog2(CYC_COUNT + 1);
  typedef logic [STATE_BITS-1:0] state_t;

  logic [DIVIDEND_W-1:0] work, quo_r;
  logic [DIVISOR_W-1:0]  breg;
  deg_t                  degb;
  logic                  dz;
  state_t                state;

  deg_t   ld_deg;
  logic   ld_zero;
  state_t ld_state;
  logic   go;

  cl_lead_one u_lead (.v(bus.B), .deg(ld_deg), .zero(ld_zero));

  // A start only counts when the pipeline is not stalled.
  assign go = bus.start && !bus.stall;

  // Initial chunk count for a new operation.
`ifdef CLDIV_EARLY_EXIT_EN
  assign ld_state = ld_zero ? '0 :
    state_t'((DIVIDEND_W - int'(ld_deg) + STEPS_PER_CYCLE - 1) / STEPS_PER_CYCLE);
`else
  assign ld_state = state_t'(CYC_COUNT);
`endif

  // Lowest dividend index handled by the current chunk.
  logic [6:0] base;
  assign base = 7'((32'(state) - 32'd1) * STEPS_PER_CYCLE);

  // One reduction step per quotient bit, highest index of the chunk first.
  logic [DIVIDEND_W-1:0] wc [STEPS_PER_CYCLE+1];
  logic [DIVIDEND_W-1:0] qc [STEPS_PER_CYCLE+1];
  assign wc[0] = work;
  assign qc[0] = quo_r;

  for (genvar j = 0; j < STEPS_PER_CYCLE; j++) begin : g_step
    logic [6:0] idx;
    logic [7:0] pos;
    logic       hit;
    assign idx = base + 7'(STEPS_PER_CYCLE - 1 - j);
    assign pos = {1'b0, idx} + {3'b0, degb};
    assign hit = !dz && (pos <= 8'd63) && wc[j][pos[5:0]];
    assign wc[j+1] = hit ? (wc[j] ^ ({32'b0, breg} << idx)) : wc[j];
    assign qc[j+1] = hit ? (qc[j] | (64'd1 << idx)) : qc[j];
  end

  // Operand load, chunk step and countdown; stall freezes everything.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      work  <= '0;
      quo_r <= '0;
      breg  <= '0;
      degb  <= '0;
      dz    <= 1'b0;
      state <= '0;
    end else if (!bus.stall) begin
      if (bus.start) begin
        work  <= bus.A;
        quo_r <= '0;
        breg  <= bus.B;
        degb  <= ld_deg;
        dz    <= ld_zero;
        state <= ld_state;
      end else if (state != '0) begin
        work  <= wc[STEPS_PER_CYCLE];
        quo_r <= qc[STEPS_PER_CYCLE];
        state <= state - state_t'(1);
      end
    end
  end

  // Results are plain register views; eoc drops as soon as a start is accepted.
  assign bus.eoc      = (state == '0) && !go;
  assign bus.quo      = quo_r;
  assign bus.rem      = work[DIVISOR_W-1:0];
  assign bus.div_zero = dz;
endmodule

// File: tb/tb_cldiv.sv
// Self-checking bench for cldiv: directed vectors, random operands against a
// long-division reference, stall, restart and mid-operation reset.
module tb_cldiv;
  localparam int STEPS = 8;
  localparam int TMO   = 200;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cldiv_if bus();
  cldiv #(.STEPS_PER_CYCLE(STEPS)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Reference: schoolbook polynomial long division over GF(2).
  function automatic int deg_of(input logic [31:0] b);
    int d;
    d = -1;
    for (int i = 0; i < 32; i++) if (b[i]) d = i;
    return d;
  endfunction

  function automatic void ref_div(input logic [63:0] a, input logic [31:0] b,
                                  output logic [63:0] q, output logic [31:0] r);
    logic [63:0] w;
    int d;
    w = a;
    q = '0;
    d = deg_of(b);
    if (d >= 0) begin
      for (int p = 63; p >= d; p--) begin
        if (w[p]) begin
          w = w ^ (64'(b) << (p - d));
          q[p - d] = 1'b1;
        end
      end
    end
    r = w[31:0];
  endfunction

  function automatic int ref_lat(input logic [31:0] b);
`ifdef CLDIV_EARLY_EXIT_EN
    if (b == 0) return 0;
    return (64 - deg_of(b) + STEPS - 1) / STEPS;
`else
    return 64 / STEPS;
`endif
  endfunction

  function automatic logic [95:0] clmul(input logic [63:0] q, input logic [31:0] b);
    logic [95:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) if (b[i]) acc = acc ^ ({32'b0, q} << i);
    return acc;
  endfunction

  // Present operands with start for one cycle; eoc must drop in that cycle.
  task automatic launch(input logic [63:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.start = 1'b1;
    #1;
    checks++;
    if (bus.eoc !== 1'b0) begin
      failures++;
      $display("FAIL eoc_start_cycle got=%b want=0", bus.eoc);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = {$urandom, $urandom};
    bus.B = $urandom;
  endtask

  // Count cycles with eoc low, bounded.
  task automatic wait_eoc(inout int lat);
    while (bus.eoc !== 1'b1 && lat < TMO) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.start = 1'b0; bus.stall = 1'b0; bus.A = '0; bus.B = '0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (bus.eoc !== 1'b1)      begin failures++; $display("FAIL reset_eoc got=%b want=1", bus.eoc); end
    if (bus.quo !== 64'd0)     begin failures++; $display("FAIL reset_quo got=%h want=0", bus.quo); end
    if (bus.rem !== 32'd0)     begin failures++; $display("FAIL reset_rem got=%h want=0", bus.rem); end
    if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b want=0", bus.div_zero); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [63:0] a;
    logic [31:0] b;
    logic [63:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  task automatic test_directed;
    vec_t v [6];
    int lat;
    v[0] = '{64'h13, 32'h3, 64'hE, 32'h1, 1'b0};
    v[1] = '{64'h1_0000_0001, 32'h3, 64'hFFFF_FFFF, 32'h0, 1'b0};
    v[2] = '{64'h11, 32'h5, 64'h5, 32'h0, 1'b0};
    v[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'h8000_0000, 64'h1_FFFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    v[4] = '{64'h0123_4567_89AB_CDEF, 32'h0, 64'h0, 32'h89AB_CDEF, 1'b1};
    v[5] = '{64'hDEAD_BEEF_CAFE_F00D, 32'h1, 64'hDEAD_BEEF_CAFE_F00D, 32'h0, 1'b0};
    foreach (v[k]) begin
      launch(v[k].a, v[k].b);
      lat = 0;
      wait_eoc(lat);
      checks += 4;
      if (lat !== ref_lat(v[k].b)) begin failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, ref_lat(v[k].b)); end
      if (bus.quo !== v[k].q)       begin failures++; $display("FAIL dir%0d_quo got=%h want=%h", k, bus.quo, v[k].q); end
      if (bus.rem !== v[k].r)       begin failures++; $display("FAIL dir%0d_rem got=%h want=%h", k, bus.rem, v[k].r); end
      if (bus.div_zero !== v[k].dz) begin failures++; $display("FAIL dir%0d_dz got=%b want=%b", k, bus.div_zero, v[k].dz); end
    end
  endtask

  task automatic test_random;
    logic [63:0] a, q;
    logic [31:0] b, r;
    int lat;
    for (int n = 0; n < 40; n++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom >> $urandom_range(0, 31);
        2: b = 32'($urandom_range(0, 3));
        default: b = 32'd1 << $urandom_range(0, 31);
      endcase
      ref_div(a, b, q, r);
      launch(a, b);
      lat = 0;
      wait_eoc(lat);
      checks += 4;
      if (lat !== ref_lat(b))          begin failures++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, lat, ref_lat(b)); end
      if (bus.quo !== q)               begin failures++; $display("FAIL rnd%0d_quo a=%h b=%h got=%h want=%h", n, a, b, bus.quo, q); end
      if (bus.rem !== r)               begin failures++; $display("FAIL rnd%0d_rem a=%h b=%h got=%h want=%h", n, a, b, bus.rem, r); end
      if (bus.div_zero !== (b == 0))   begin failures++; $display("FAIL rnd%0d_dz got=%b want=%b", n, bus.div_zero, (b == 0)); end
      if (b != 0) begin
        checks++;
        if ((clmul(bus.quo, b) ^ {64'b0, bus.rem}) !== {32'b0, a}) begin
          failures++;
          $display("FAIL rnd%0d_identity got=%h want=%h", n, clmul(bus.quo, b) ^ {64'b0, bus.rem}, {32'b0, a});
        end
      end
    end
  endtask

  task automatic test_stall;
    int lat;
    launch(64'h13, 32'h3);
    lat = 0;
    repeat (2) begin lat++; @(negedge clk); end
    // Stall mid-operation with a start pulse that must be dropped.
    repeat (3) begin
      bus.stall = 1'b1; bus.start = 1'b1; bus.A = 64'h11; bus.B = 32'h5;
      #1;
      checks++;
      if (bus.eoc !== 1'b0) begin failures++; $display("FAIL stall_eoc got=%b want=0", bus.eoc); end
      lat++;
      @(negedge clk);
    end
    bus.stall = 1'b0; bus.start = 1'b0;
    wait_eoc(lat);
    checks += 3;
    if (lat !== ref_lat(32'h3) + 3) begin failures++; $display("FAIL stall_latency got=%0d want=%0d", lat, ref_lat(32'h3) + 3); end
    if (bus.quo !== 64'hE)          begin failures++; $display("FAIL stall_quo got=%h want=e", bus.quo); end
    if (bus.rem !== 32'h1)          begin failures++; $display("FAIL stall_rem got=%h want=1", bus.rem); end
    // Idle stall: start dropped, eoc and results held.
    bus.stall = 1'b1; bus.start = 1'b1; bus.A = 64'h11; bus.B = 32'h5;
    #1;
    checks++;
    if (bus.eoc !== 1'b1) begin failures++; $display("FAIL idle_stall_eoc got=%b want=1", bus.eoc); end
    @(negedge clk);
    bus.stall = 1'b0; bus.start = 1'b0;
    #1;
    checks += 2;
    if (bus.eoc !== 1'b1)  begin failures++; $display("FAIL idle_stall_eoc_after got=%b want=1", bus.eoc); end
    if (bus.quo !== 64'hE) begin failures++; $display("FAIL idle_stall_quo got=%h want=e", bus.quo); end
  endtask

  task automatic test_restart;
    int lat;
    launch(64'h13, 32'h3);
    repeat (2) @(negedge clk);
    launch(64'h11, 32'h5);
    lat = 0;
    wait_eoc(lat);
    checks += 3;
    if (lat !== ref_lat(32'h5)) begin failures++; $display("FAIL restart_latency got=%0d want=%0d", lat, ref_lat(32'h5)); end
    if (bus.quo !== 64'h5)      begin failures++; $display("FAIL restart_quo got=%h want=5", bus.quo); end
    if (bus.rem !== 32'h0)      begin failures++; $display("FAIL restart_rem got=%h want=0", bus.rem); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] bs [2];
    bs[0] = 32'h0;
    bs[1] = 32'h3;
    foreach (bs[k]) begin
      launch(64'h0123_4567_89AB_CDEF, bs[k]);
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      checks += 4;
      if (bus.eoc !== 1'b1)      begin failures++; $display("FAIL rstmid%0d_eoc got=%b want=1", k, bus.eoc); end
      if (bus.quo !== 64'd0)     begin failures++; $display("FAIL rstmid%0d_quo got=%h want=0", k, bus.quo); end
      if (bus.rem !== 32'd0)     begin failures++; $display("FAIL rstmid%0d_rem got=%h want=0", k, bus.rem); end
      if (bus.div_zero !== 1'b0) begin failures++; $display("FAIL rstmid%0d_dz got=%b want=0", k, bus.div_zero); end
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.quo !== 64'd0) begin failures++; $display("FAIL rstmid%0d_quo_after got=%h want=0", k, bus.quo); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_stall;
    test_restart;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
